// File: rtl/pipe_pkg.sv
// Shared definitions for the IF stage of the 5-stage pipeline.
// Covers next-PC select encodings, boot/NOP constants and the fetch FSM states.
package pipe_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JR  = 2'b10;
    localparam logic [1:0] PCSRC_J   = 2'b11;

    localparam logic [31:0] RESET_PC = 32'hFFFF_FFFC;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/npc_mux.sv
// Next-PC selection: pc+4 adder and 4:1 target mux driven by the ID-stage pcsrc.
module npc_mux
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] pc,
    input  logic [1:0]        pcsrc,
    input  logic [DATA_W-1:0] bpc,
    input  logic [DATA_W-1:0] rpc,
    input  logic [DATA_W-1:0] jpc,
    output logic [DATA_W-1:0] pc4,
    output logic [DATA_W-1:0] npc
);

    // Wraps modulo 2^DATA_W, so the boot PC of all-ones-minus-3 steps to zero.
    assign pc4 = pc + DATA_W'(4);

    always_comb begin
        npc = pc4;
        case (pcsrc)
            PCSRC_SEQ: npc = pc4;
            PCSRC_BR:  npc = bpc;
            PCSRC_JR:  npc = rpc;
            PCSRC_J:   npc = jpc;
            default:   npc = pc4;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// IF-stage controller: drives PC updates and the imem handshake, and owns the IF/ID
// register together with the hold buffer used while ID stalls.
//
// state | meaning
// BOOT  | first cycle after reset; step PC from the reset value to pc+4, no fetch
// REQ   | fetch outstanding at pc; accept, bubble or park the word on stall
// HOLD  | fetched word parked in the hold buffer until ID frees up
module fetch_unit
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_INST = pipe_pkg::NOP_INST
) (
    input  logic              clock,
    input  logic              reset_0,
    input  logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] npc,
    output logic              wpc,
    output logic              imem_req,
    output logic [DATA_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic [1:0]        pcsrc,
    input  logic [DATA_W-1:0] bpc,
    input  logic [DATA_W-1:0] rpc,
    input  logic [DATA_W-1:0] jpc,
    input  logic              stall_id,
    input  logic              flush,
    output logic [DATA_W-1:0] ifid_pc4,
    output logic [DATA_W-1:0] ifid_inst,
    output logic              ifid_valid
);

    fetch_state_t      state, state_nx;
    logic [1:0]        sel;
    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] hold_pc4, hold_inst;
    logic              take_mem, take_hold, bubble, cap_hold, kill;

    npc_mux #(.DATA_W(DATA_W)) u_npc_mux (
        .pc    (pc),
        .pcsrc (sel),
        .bpc   (bpc),
        .rpc   (rpc),
        .jpc   (jpc),
        .pc4   (pc4),
        .npc   (npc)
    );

    assign imem_addr = pc;

    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) state <= BOOT;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        sel       = pcsrc;
        wpc       = 1'b0;
        imem_req  = 1'b0;
        take_mem  = 1'b0;
        take_hold = 1'b0;
        bubble    = 1'b0;
        cap_hold  = 1'b0;
        kill      = 1'b0;
        case (state)
            BOOT: begin
                // State is forced to BOOT while reset is low, so gating here keeps wpc quiet in reset.
                sel      = PCSRC_SEQ;
                wpc      = reset_0;
                state_nx = REQ;
            end
            REQ: begin
                imem_req = 1'b1;
                if (flush) begin
                    wpc    = 1'b1;
                    kill   = 1'b1;
                    bubble = 1'b1;
                end else if (imem_ready && !stall_id) begin
                    wpc      = 1'b1;
                    take_mem = 1'b1;
                end else if (imem_ready && stall_id) begin
                    cap_hold = 1'b1;
                    state_nx = HOLD;
                end else if (!stall_id) begin
                    bubble = 1'b1;
                end
            end
            HOLD: begin
                if (flush) begin
                    wpc      = 1'b1;
                    kill     = 1'b1;
                    bubble   = 1'b1;
                    state_nx = REQ;
                end else if (!stall_id) begin
                    wpc       = 1'b1;
                    take_hold = 1'b1;
                    state_nx  = REQ;
                end
            end
            default: state_nx = BOOT;
        endcase
    end

    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            ifid_pc4   <= '0;
            ifid_inst  <= NOP_INST;
            ifid_valid <= 1'b0;
        end else if (bubble) begin
            ifid_inst  <= NOP_INST;
            ifid_valid <= 1'b0;
        end else if (take_mem) begin
            ifid_pc4   <= pc4;
            ifid_inst  <= imem_rdata;
            ifid_valid <= 1'b1;
        end else if (take_hold) begin
            ifid_pc4   <= hold_pc4;
            ifid_inst  <= hold_inst;
            ifid_valid <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            hold_pc4  <= '0;
            hold_inst <= NOP_INST;
        end else if (kill) begin
            hold_pc4  <= '0;
            hold_inst <= NOP_INST;
        end else if (cap_hold) begin
            hold_pc4  <= pc4;
            hold_inst <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: models the PC register and a zero/variable-latency imem,
// and scoreboards the instructions expected to land in IF/ID.
module tb_fetch_unit;
    import pipe_pkg::*;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] inst;
    } ent_t;

    logic        clock = 1'b0;
    logic        reset_0;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        wpc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [1:0]  pcsrc;
    logic [31:0] bpc, rpc, jpc;
    logic        stall_id;
    logic        flush;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_inst;
    logic        ifid_valid;

    int   n_chk  = 0;
    int   n_fail = 0;
    ent_t sb_q[$];
    logic [31:0] last_pc4, last_inst;
    logic        last_valid;

    fetch_unit dut (
        .clock      (clock),
        .reset_0    (reset_0),
        .pc         (pc),
        .npc        (npc),
        .wpc        (wpc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .pcsrc      (pcsrc),
        .bpc        (bpc),
        .rpc        (rpc),
        .jpc        (jpc),
        .stall_id   (stall_id),
        .flush      (flush),
        .ifid_pc4   (ifid_pc4),
        .ifid_inst  (ifid_inst),
        .ifid_valid (ifid_valid)
    );

    always #5 clock = ~clock;

    // PC register living outside the fetch unit
    always @(posedge clock or negedge reset_0) begin
        if (!reset_0)  pc <= RESET_PC;
        else if (wpc)  pc <= npc;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h8) ? 32'h8C22_0004 : (32'h2000_0000 | a);
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_wpc", {31'b0, wpc}, 32'd0);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_npc", npc, 32'h0);
        chk("rst_valid", {31'b0, ifid_valid}, 32'd0);
        chk("rst_inst", ifid_inst, NOP_INST);
        chk("rst_pc4", ifid_pc4, 32'h0);
    endtask

    // kind: 0 bubble, 1 pop scoreboard, 2 IF/ID unchanged, 3 flush (drop pending, bubble)
    task automatic tick(input logic rdy, input logic stl, input logic fl, input logic [1:0] sel,
                        input logic [31:0] addr, input logic req, input logic w,
                        input logic [31:0] nxt, input logic push, input int kind);
        ent_t e;
        imem_ready = rdy;
        stall_id   = stl;
        flush      = fl;
        pcsrc      = sel;
        #1;
        chk("imem_addr", imem_addr, addr);
        chk("imem_req", {31'b0, imem_req}, {31'b0, req});
        chk("wpc", {31'b0, wpc}, {31'b0, w});
        if (w) chk("npc", npc, nxt);
        if (push) begin
            e.pc4  = addr + 32'd4;
            e.inst = mem_word(addr);
            sb_q.push_back(e);
        end
        @(posedge clock);
        #1;
        case (kind)
            0, 3: begin
                if (kind == 3) sb_q.delete();
                last_valid = 1'b0;
                last_inst  = NOP_INST;
            end
            1: begin
                if (sb_q.size() == 0) begin
                    chk("sb_empty", 32'd0, 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    last_pc4   = e.pc4;
                    last_inst  = e.inst;
                    last_valid = 1'b1;
                end
            end
            default: ;
        endcase
        chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, last_valid});
        chk("ifid_inst", ifid_inst, last_inst);
        chk("ifid_pc4", ifid_pc4, last_pc4);
        @(negedge clock);
    endtask

    initial begin
        reset_0    = 1'b0;
        imem_ready = 1'b0;
        stall_id   = 1'b0;
        flush      = 1'b0;
        pcsrc      = PCSRC_SEQ;
        bpc        = 32'h20;
        rpc        = 32'h10;
        jpc        = 32'h400;
        last_pc4   = 32'h0;
        last_inst  = NOP_INST;
        last_valid = 1'b0;
        #12;
        check_reset_outputs();
        @(negedge clock);
        reset_0 = 1'b1;

        // BOOT ignores pcsrc and steps FFFFFFFC -> 0
        tick(0, 0, 0, PCSRC_J,   32'hFFFF_FFFC, 0, 1, 32'h0,   0, 2);
        // back-to-back sequential fetch
        tick(1, 0, 0, PCSRC_SEQ, 32'h0,  1, 1, 32'h4,   1, 1);
        tick(1, 0, 0, PCSRC_SEQ, 32'h4,  1, 1, 32'h8,   1, 1);
        // stall for three cycles with the word parked in HOLD
        tick(1, 1, 0, PCSRC_SEQ, 32'h8,  1, 0, 32'h0,   1, 2);
        tick(0, 1, 0, PCSRC_SEQ, 32'h8,  0, 0, 32'h0,   0, 2);
        tick(1, 1, 0, PCSRC_SEQ, 32'h8,  0, 0, 32'h0,   0, 2);
        tick(0, 0, 0, PCSRC_SEQ, 32'h8,  0, 1, 32'hC,   0, 1);
        // jr redirect to 0x10
        tick(1, 0, 0, PCSRC_JR,  32'hC,  1, 1, 32'h10,  1, 1);
        // two wait cycles -> two bubbles, then a stalled wait leaves IF/ID alone
        tick(0, 0, 0, PCSRC_SEQ, 32'h10, 1, 0, 32'h0,   0, 0);
        tick(0, 0, 0, PCSRC_SEQ, 32'h10, 1, 0, 32'h0,   0, 0);
        tick(0, 1, 0, PCSRC_SEQ, 32'h10, 1, 0, 32'h0,   0, 2);
        // accept with branch to 0x20
        tick(1, 0, 0, PCSRC_BR,  32'h10, 1, 1, 32'h20,  1, 1);
        // park at 0x20, then flush out of HOLD to jump target
        tick(1, 1, 0, PCSRC_SEQ, 32'h20, 1, 0, 32'h0,   1, 2);
        tick(0, 1, 1, PCSRC_J,   32'h20, 0, 1, 32'h400, 0, 3);
        // ready, stall and flush together: flush wins
        tick(1, 1, 1, PCSRC_SEQ, 32'h400, 1, 1, 32'h404, 0, 3);
        tick(1, 0, 0, PCSRC_SEQ, 32'h404, 1, 1, 32'h408, 1, 1);
        tick(0, 0, 0, PCSRC_SEQ, 32'h408, 1, 0, 32'h0,   0, 0);

        // asynchronous reset in the middle of a wait
        #2;
        reset_0 = 1'b0;
        #1;
        check_reset_outputs();
        sb_q.delete();
        last_pc4   = 32'h0;
        last_inst  = NOP_INST;
        last_valid = 1'b0;
        @(negedge clock);
        reset_0 = 1'b1;
        tick(0, 0, 0, PCSRC_BR,  32'hFFFF_FFFC, 0, 1, 32'h0, 0, 2);
        tick(1, 0, 0, PCSRC_SEQ, 32'h0, 1, 1, 32'h4, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- IF-stage controller for the 5-stage MIPS pipeline.
- Sits between the 32-bit PC register and the IF/ID boundary:
  - consumes the PC register output;
  - produces its next value (npc) and write enable (wpc);
  - drives the instruction-memory request handshake;
  - owns the IF/ID pipeline register, including stall hold, flush and bubble insertion.

Parameters:
- DATA_W, 32, width of PC and instruction words.
- RESET_PC, 32'hFFFFFFFC, value the PC register holds out of reset; first PC+4 is therefore 0.
- NOP_INST, 32'h00000000, instruction word presented in IF/ID when not valid.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset_0  in  1  asynchronous, active-low reset.
- pc  in  32  current PC, from the PC register output.
- npc  out  32  next PC, to the PC register data input.
- wpc  out  1  PC register write enable.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  32  fetch address; always equals pc.
- imem_ready  in  1  rdata valid for imem_addr this cycle.
- imem_rdata  in  32  fetched instruction.
- pcsrc  in  2  next-PC select from ID: 00 pc+4, 01 bpc, 10 rpc, 11 jpc.
- bpc  in  32  branch target.
- rpc  in  32  jr register target.
- jpc  in  32  jump target.
- stall_id  in  1  ID cannot accept a new instruction (load-use hazard).
- flush  in  1  redirect: kill IF/ID and in-flight fetch, load target per pcsrc.
- ifid_pc4  out  32  registered pc+4 of the instruction in IF/ID.
- ifid_inst  out  32  registered instruction.
- ifid_valid  out  1  IF/ID holds a real instruction.

Behaviour:
Reset and general rules
- Reset (reset_0=0, async) forces:
  - state=BOOT;
  - ifid_pc4=0, ifid_inst=NOP_INST, ifid_valid=0;
  - hold buffer cleared.
- Outputs driven combinationally from state, all at their reset values during reset: wpc=0, imem_req=0, npc=pc+4.
- Arithmetic: pc4 = pc+4, mod 2^32; FFFFFFFC+4 wraps to 0.
- npc mux: pcsrc 00 → pc4, 01 → bpc, 10 → rpc, 11 → jpc.

State BOOT (one cycle after reset release)
- wpc=1 with npc forced to pc4, ignoring pcsrc.
- imem_req=0; IF/ID unchanged (invalid).
- Next state REQ.

State REQ
- imem_req=1.
- imem_ready & ~stall_id:
  - IF/ID <= {pc4, imem_rdata, 1};
  - wpc=1, npc per pcsrc.
- imem_ready & stall_id:
  - capture imem_rdata and pc4 into the hold buffer;
  - wpc=0, IF/ID unchanged;
  - next state HOLD.
- ~imem_ready & ~stall_id: IF/ID valid <= 0 (bubble, inst=NOP_INST); wpc=0.
- ~imem_ready & stall_id: IF/ID unchanged; wpc=0.

State HOLD
- imem_req=0; wpc=0 while stall_id=1.
- On ~stall_id:
  - IF/ID <= hold buffer with valid=1;
  - wpc=1, npc per pcsrc;
  - next state REQ.

Flush (highest priority after reset, any state except BOOT)
- wpc=1, npc per pcsrc.
- IF/ID valid <= 0, inst <= NOP_INST.
- Any imem_rdata this cycle and any hold buffer are discarded.
- Next state REQ.
- Flush overrides stall_id.
- Flush during BOOT is ignored.

Timing and boundary rules
- imem latency is variable (≥0 wait cycles). imem_addr may change after a flush; the memory answers for the address present in the ready cycle.
- Exactly one pc write per accepted or redirected instruction; no double-issue.
- Simultaneous imem_ready, stall_id and flush → flush wins.

Decomposition:
- Shared package `pipe_pkg`:
  - PCSRC_SEQ/BR/JR/J encodings;
  - RESET_PC;
  - NOP_INST;
  - FSM state typedef {BOOT, REQ, HOLD}.
- One natural sub-module: `npc_mux` (4:1 next-PC select plus pc+4 adder).
- IF/ID register and FSM live in fetch_unit.

Test Plan:
- Reset release with pc=FFFFFFFC → cycle 1: wpc=1, npc=0, imem_req=0; cycle 2: imem_req=1, imem_addr=0.
- pc=0, imem_ready=1 every cycle, pcsrc=00 → IF/ID shows pc4=4,8,C… back-to-back with valid=1.
- pc=8, imem_ready=1, stall_id=1 for 3 cycles, inst=0x8C220004 → wpc=0 and IF/ID frozen; after stall drops, IF/ID={0xC, 0x8C220004, 1}, npc=0xC.
- imem_ready=0 for 2 cycles at pc=0x10 → two bubbles (valid=0, inst=0), pc held at 0x10, then accepted.
- During HOLD: flush=1, pcsrc=11, jpc=0x400 → npc=0x400, wpc=1, IF/ID valid=0, buffer dropped, next imem_addr=0x400.
- reset_0 asserted mid-WAIT → outputs return to reset values asynchronously; BOOT sequence repeats.
